frame_stream_engine: RTL and testbench
======================================

FRAME_STREAM_ENGINE -- requirements
Module: frame_stream_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 540, pixels per row (>=2).
REQ-002 SHALL have parameter IMG_H, default 540, rows per frame (>=2).
REQ-003 SHALL have parameter PIX_W, default 8, pixel data width.
REQ-004 SHALL have parameter ADDR_W, default 19, memory address width; elaboration SHALL fail if 2**ADDR_W < IMG_W*IMG_H.
REQ-005 SHALL have parameter RD_LAT, default 1, memory read latency in cycles (1..3).
REQ-006 SHALL have these ports, one clock, synchronous active-low reset:
  clk  in  1  system clock
  rst_n  in  1  synchronous active-low reset
  start_i  in  1  frame start request; rising edge triggers
  cont_i  in  1  1 = continuous frames; sampled in DONE
  abort_i  in  1  cancel current frame
  mem_en_o  out  1  memory read enable
  mem_addr_o  out  ADDR_W  linear read address
  mem_data_i  in  PIX_W  read data, valid RD_LAT cycles after mem_en_o
  pix_o  out  PIX_W  output pixel
  pix_valid_o  out  1  pix_o valid
  pix_ready_i  in  1  downstream accepts
  sof_o  out  1  qualifies first pixel of frame
  eol_o  out  1  qualifies last pixel of row
  eof_o  out  1  qualifies last pixel of frame
  busy_o  out  1  state != IDLE
  frame_done_o  out  1  one-cycle pulse per completed frame
  row_o  out  10  row of current output pixel
  col_o  out  10  column of current output pixel

Function
REQ-007 SHALL implement states IDLE, FETCH, DRAIN, DONE.
REQ-008 IDLE->FETCH when start_i is sampled 1 and was 0 the previous cycle; a held-high start_i SHALL start exactly one frame.
REQ-009 In FETCH, SHALL assert mem_en_o with mem_addr_o = 0,1,..,IMG_W*IMG_H-1 in order, one address per cycle when credit is available.
REQ-010 Credit: read SHALL issue only if (FIFO occupancy + reads in flight) < 4.
REQ-011 FETCH->DRAIN in the cycle after the last address issues.
REQ-012 DRAIN->DONE when no reads are in flight, the FIFO is empty, and no pixel is pending on the output.
REQ-013 DONE SHALL last one cycle with frame_done_o=1; then ->FETCH (address 0) if cont_i=1, else ->IDLE.
REQ-014 Returned data SHALL be written into a 4-entry FIFO in the cycle it is valid; pix_o/pix_valid_o come from the FIFO head.
REQ-015 Latency: start edge sampled at edge k -> mem_en_o in cycle k+1 -> pix_valid_o first high in cycle k+2+RD_LAT.
REQ-016 Transfer occurs when pix_valid_o & pix_ready_i; pix_o/pix_valid_o SHALL hold stable while pix_valid_o=1 and pix_ready_i=0.
REQ-017 row_o/col_o SHALL advance on each transfer; col wraps IMG_W-1->0 incrementing row; both clear after the eof transfer.
REQ-018 sof_o = (row,col)=(0,0); eol_o = col=IMG_W-1; eof_o = eol_o & row=IMG_H-1; all gated by pix_valid_o.
REQ-019 abort_i=1 in any state SHALL force IDLE next cycle: flush FIFO, clear counters, discard in-flight returns, no frame_done_o; abort has priority over start edge.
REQ-020 FIFO write and read in the same cycle SHALL keep occupancy unchanged; FIFO never over- or underflows.
REQ-021 mem_en_o SHALL be 0 outside FETCH.

Reset
REQ-022 On rst_n=0 at a clock edge: state IDLE; all outputs 0; mem_addr_o=0; FIFO empty; in-flight tracker cleared; start edge history cleared; reset mid-frame behaves as abort.

Structure
REQ-023 State enum, FIFO depth (4) and RD_LAT bounds SHALL live in the shared package fse_pkg.
REQ-024 The FIFO SHALL be one sub-module, fse_pix_fifo (depth 4, width PIX_W, occupancy output).
REQ-025 In-flight tracking SHALL be an RD_LAT-deep valid shift register, cleared on abort.

Verification
REQ-026 IMG_W=4, IMG_H=3, RD_LAT=1, ready=1, one start pulse -> 12 pixels = mem[0..11], first valid 3 cycles after start edge, eol on pixels 4/8/12, eof on 12, one frame_done_o.
REQ-027 Same with pix_ready_i toggling 1,0,0,1 repeating -> identical 12-pixel sequence, no drop/duplicate, stable pix_o when stalled, mem_en_o never issued when occupancy+in-flight=4.
REQ-028 RD_LAT=3, ready=1 -> correct data order, first valid at k+5, throughput capped by credit, no overflow.
REQ-029 cont_i=1 -> two frames back-to-back, second sof follows first eof, two frame_done_o pulses, busy_o stays 1.
REQ-030 abort_i at pixel 5 of 12 -> IDLE next cycle, pix_valid_o=0, no frame_done_o; a new start edge then replays from mem[0] with sof.
REQ-031 start_i held high 40 cycles -> exactly one frame; rst_n low mid-FETCH -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fse_pkg.sv
// Shared types and constants for the frame stream engine: FSM states,
// pixel FIFO geometry and the legal memory read-latency range.
package fse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fse_state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int POS_W      = 10;

endpackage

// File: rtl/fse_pix_fifo.sv
// Four-entry pixel FIFO with flush; the head entry is visible combinationally
// so the output stage can present it the same cycle it becomes valid.
module fse_pix_fifo
  import fse_pkg::*;
#(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               wr_en_i,
  input  logic [W-1:0]       wr_data_i,
  input  logic               rd_en_i,
  output logic [W-1:0]       rd_data_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   count_o
);

  localparam logic [FIFO_AW:0] L_FULL = FIFO_DEPTH[FIFO_AW:0];

  logic [W-1:0]       r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_wr;
  logic               w_rd;

  // Guards keep the occupancy legal even if a caller misbehaves.
  assign w_wr = wr_en_i && (r_count != L_FULL);
  assign w_rd = rd_en_i && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= wr_data_i;
  end

  assign rd_data_o = r_mem[r_rptr];
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;

endmodule

// File: rtl/frame_stream_engine.sv
// Streams a frame out of a latency-RD_LAT memory as a raster pixel stream,
// with credit-based read issue into a 4-entry FIFO and sof/eol/eof tagging.
module frame_stream_engine
  import fse_pkg::*;
#(
  parameter int IMG_W  = 540,
  parameter int IMG_H  = 540,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              cont_i,
  input  logic              abort_i,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [PIX_W-1:0]  mem_data_i,
  output logic [PIX_W-1:0]  pix_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic              sof_o,
  output logic              eol_o,
  output logic              eof_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [POS_W-1:0]  row_o,
  output logic [POS_W-1:0]  col_o
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] L_LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [POS_W-1:0]  L_LAST_COL  = POS_W'(IMG_W - 1);
  localparam logic [POS_W-1:0]  L_LAST_ROW  = POS_W'(IMG_H - 1);
  localparam logic [FIFO_AW:0]  L_DEPTH     = FIFO_DEPTH[FIFO_AW:0];

  generate
    if ((64'd1 << ADDR_W) < 64'(NPIX)) begin : g_bad_addr_w
      $error("ADDR_W too narrow for IMG_W*IMG_H");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("RD_LAT out of range");
    end
  endgenerate

  fse_state_t        r_state;
  logic              r_start_d;
  logic [ADDR_W-1:0] r_addr;
  logic [RD_LAT-1:0] r_vld;
  logic [POS_W-1:0]  r_row;
  logic [POS_W-1:0]  r_col;

  logic [RD_LAT-1:0] w_vld_next;
  logic [FIFO_AW:0]  w_inflight;
  logic [FIFO_AW:0]  w_count;
  logic [PIX_W-1:0]  w_head;
  logic              w_empty;
  logic              w_valid;
  logic              w_issue;
  logic              w_xfer;
  logic              w_wr;
  logic              w_start_edge;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + {{FIFO_AW{1'b0}}, r_vld[i]};
    end
  end

  generate
    if (RD_LAT == 1) begin : g_vld_one
      assign w_vld_next = w_issue;
    end else begin : g_vld_many
      assign w_vld_next = {r_vld[RD_LAT-2:0], w_issue};
    end
  endgenerate

  // A read only goes out if its data is guaranteed a FIFO slot on return.
  assign w_issue      = (r_state == ST_FETCH) && ((w_count + w_inflight) < L_DEPTH);
  assign w_wr         = r_vld[RD_LAT-1] && !abort_i;
  assign w_valid      = !w_empty;
  assign w_xfer       = w_valid && pix_ready_i;
  assign w_start_edge = start_i && !r_start_d;

  fse_pix_fifo #(.W(PIX_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (abort_i),
    .wr_en_i   (w_wr),
    .wr_data_i (mem_data_i),
    .rd_en_i   (w_xfer),
    .rd_data_o (w_head),
    .empty_o   (w_empty),
    .count_o   (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_start_d <= 1'b0;
      r_addr    <= '0;
      r_vld     <= '0;
      r_row     <= '0;
      r_col     <= '0;
    end else begin
      r_start_d <= start_i;
      if (abort_i) begin
        r_state <= ST_IDLE;
        r_addr  <= '0;
        r_vld   <= '0;
        r_row   <= '0;
        r_col   <= '0;
      end else begin
        r_vld <= w_vld_next;
        if (w_xfer) begin
          if (r_col == L_LAST_COL) begin
            r_col <= '0;
            r_row <= (r_row == L_LAST_ROW) ? '0 : r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        case (r_state)
          ST_IDLE: begin
            if (w_start_edge) r_state <= ST_FETCH;
          end
          ST_FETCH: begin
            if (w_issue) begin
              if (r_addr == L_LAST_ADDR) begin
                r_addr  <= '0;
                r_state <= ST_DRAIN;
              end else begin
                r_addr <= r_addr + 1'b1;
              end
            end
          end
          ST_DRAIN: begin
            if ((w_inflight == '0) && w_empty) r_state <= ST_DONE;
          end
          ST_DONE: begin
            r_state <= cont_i ? ST_FETCH : ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mem_en_o     = w_issue;
  assign mem_addr_o   = r_addr;
  assign pix_valid_o  = w_valid;
  assign pix_o        = w_valid ? w_head : '0;
  assign sof_o        = w_valid && (r_row == '0) && (r_col == '0);
  assign eol_o        = w_valid && (r_col == L_LAST_COL);
  assign eof_o        = w_valid && (r_col == L_LAST_COL) && (r_row == L_LAST_ROW);
  assign busy_o       = (r_state != ST_IDLE);
  assign frame_done_o = (r_state == ST_DONE);
  assign row_o        = r_row;
  assign col_o        = r_col;

endmodule

// File: tb/tb_frame_stream_engine.sv
// Bench for frame_stream_engine: a RD_LAT=1 and a RD_LAT=3 instance share
// stimulus; observed transfers are compared against a raster model of a 4x3 frame.
`timescale 1ns/1ps
module tb_frame_stream_engine;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;
  localparam int AW   = 4;
  localparam int PW   = 8;
  localparam int NI   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b0;

  logic          mem_en    [NI];
  logic [AW-1:0] mem_addr  [NI];
  logic [PW-1:0] pix       [NI];
  logic          pix_valid [NI];
  logic          sof       [NI];
  logic          eol       [NI];
  logic          eof       [NI];
  logic          busy      [NI];
  logic          fdone     [NI];
  logic [9:0]    row       [NI];
  logic [9:0]    col       [NI];

  logic [PW-1:0] mem [16];
  int ec = 0;
  int n_chk = 0;
  int n_pass = 0;
  int rmode = 0;
  int pc = 0;

  logic [30:0] rec [NI][64];
  int rec_n [NI];
  int done_cnt [NI];
  int stall_bad [NI];
  int credit_bad [NI];
  int addr_bad [NI];
  int idle_en_bad [NI];
  int busy_fall [NI];
  int first_en [NI];
  int first_v [NI];

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [PW-1:0] md [3];
    logic [PW-1:0] mdat;
    int iss = 0;
    int xfer = 0;
    int eaddr = 0;
    logic pv_q = 1'b0;
    logic pr_q = 1'b0;
    logic busy_q = 1'b0;
    logic [PW-1:0] pp_q = '0;

    frame_stream_engine #(
      .IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW), .RD_LAT(LAT)
    ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .cont_i       (cont),
      .abort_i      (abort),
      .mem_en_o     (mem_en[gi]),
      .mem_addr_o   (mem_addr[gi]),
      .mem_data_i   (mdat),
      .pix_o        (pix[gi]),
      .pix_valid_o  (pix_valid[gi]),
      .pix_ready_i  (ready),
      .sof_o        (sof[gi]),
      .eol_o        (eol[gi]),
      .eof_o        (eof[gi]),
      .busy_o       (busy[gi]),
      .frame_done_o (fdone[gi]),
      .row_o        (row[gi]),
      .col_o        (col[gi])
    );

    // Memory: data for the address presented at an edge appears LAT cycles later.
    always @(posedge clk) begin
      md[0] <= mem[mem_addr[gi]];
      md[1] <= md[0];
      md[2] <= md[1];
    end
    assign mdat = md[LAT-1];

    // Observer: logs transfers and counts protocol violations for the tasks.
    always @(negedge clk) begin
      if (mem_en[gi]) begin
        if (!busy[gi]) idle_en_bad[gi]++;
        if (iss - xfer >= 4) credit_bad[gi]++;
        if (int'(mem_addr[gi]) != eaddr) addr_bad[gi]++;
        eaddr = (eaddr + 1) % NPIX;
        iss++;
        if (first_en[gi] < 0) first_en[gi] = ec + 1;
      end
      if (pix_valid[gi] && first_v[gi] < 0) first_v[gi] = ec + 1;
      if (pv_q && !pr_q && (!pix_valid[gi] || pix[gi] != pp_q)) stall_bad[gi]++;
      if (pix_valid[gi] && ready) begin
        if (rec_n[gi] < 64) rec[gi][rec_n[gi]] = {pix[gi], sof[gi], eol[gi], eof[gi], row[gi], col[gi]};
        rec_n[gi]++;
        xfer++;
      end
      if (fdone[gi]) done_cnt[gi]++;
      if (busy_q && !busy[gi]) busy_fall[gi]++;
      pv_q = pix_valid[gi];
      pr_q = ready;
      pp_q = pix[gi];
      busy_q = busy[gi];
      if (abort || !rst_n) begin
        iss = 0;
        xfer = 0;
        eaddr = 0;
        pv_q = 1'b0;
      end
    end
  end

  // Raster model: transfer j of a run is pixel j mod NPIX of the frame.
  function automatic logic [30:0] exp_rec(int j);
    int n;
    logic [9:0] r;
    logic [9:0] c;
    n = j % NPIX;
    r = 10'(n / W);
    c = 10'(n % W);
    return {mem[n], n == 0, (n % W) == (W - 1), n == (NPIX - 1), r, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    pc++;
    case (rmode)
      0:       ready = 1'b1;
      1:       ready = ((pc % 4) == 0) || ((pc % 4) == 3);
      default: ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic clear_rec();
    for (int d = 0; d < NI; d++) begin
      rec_n[d] = 0; done_cnt[d] = 0; stall_bad[d] = 0; credit_bad[d] = 0;
      addr_bad[d] = 0; idle_en_bad[d] = 0; busy_fall[d] = 0;
      first_en[d] = -1; first_v[d] = -1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int nd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      step();
      ok = (done_cnt[0] >= nd) && (done_cnt[1] >= nd) && !busy[0] && !busy[1];
    end
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step(); step();
    for (int d = 0; d < NI; d++) begin
      n_chk++;
      if ({mem_en[d], mem_addr[d], pix[d], pix_valid[d], sof[d], eol[d], eof[d], busy[d],
           fdone[d], row[d], col[d]} !== 39'd0)
        $display("FAIL reset_outputs inst%0d: got en=%b addr=%0d pix=%h v=%b busy=%b row=%0d col=%0d, want all 0",
                 d, mem_en[d], mem_addr[d], pix[d], pix_valid[d], busy[d], row[d], col[d]);
      else n_pass++;
    end
    rst_n = 1'b1;
    step(); step();
  endtask

  task automatic test_single_frame();
    bit ok;
    int e0;
    rmode = 0;
    step();
    clear_rec();
    e0 = ec;
    pulse_start();
    wait_idle(1, ok);
    n_chk++;
    if (ok !== 1'b1) $display("FAIL single_timeout: got busy after 600 cycles, want idle"); else n_pass++;
    for (int d = 0; d < NI; d++) begin
      n_chk++;
      if (first_en[d] !== e0 + 2) $display("FAIL single_first_en inst%0d: got %0d want %0d", d, first_en[d], e0 + 2);
      else n_pass++;
      n_chk++;
      if (first_v[d] !== e0 + 3 + ((d == 0) ? 1 : 3))
        $display("FAIL single_first_valid inst%0d: got %0d want %0d", d, first_v[d], e0 + 3 + ((d == 0) ? 1 : 3));
      else n_pass++;
      n_chk++;
      if (rec_n[d] !== NPIX) $display("FAIL single_count inst%0d: got %0d want %0d", d, rec_n[d], NPIX); else n_pass++;
      for (int j = 0; j < NPIX && j < rec_n[d]; j++) begin
        n_chk++;
        if (rec[d][j] !== exp_rec(j)) $display("FAIL single_pix inst%0d #%0d: got %h want %h", d, j, rec[d][j], exp_rec(j));
        else n_pass++;
      end
      n_chk++;
      if (done_cnt[d] !== 1) $display("FAIL single_done inst%0d: got %0d want 1", d, done_cnt[d]); else n_pass++;
      n_chk++;
      if (credit_bad[d] + addr_bad[d] + idle_en_bad[d] + stall_bad[d] !== 0)
        $display("FAIL single_protocol inst%0d: got credit=%0d addr=%0d idle_en=%0d stall=%0d want 0",
                 d, credit_bad[d], addr_bad[d], idle_en_bad[d], stall_bad[d]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    rmode = 1;
    pc = -1;
    clear_rec();
    pulse_start();
    wait_idle(1, ok);
    rmode = 0;
    n_chk++;
    if (ok !== 1'b1) $display("FAIL bp_timeout: got busy after 600 cycles, want idle"); else n_pass++;
    for (int d = 0; d < NI; d++) begin
      n_chk++;
      if (rec_n[d] !== NPIX) $display("FAIL bp_count inst%0d: got %0d want %0d", d, rec_n[d], NPIX); else n_pass++;
      for (int j = 0; j < NPIX && j < rec_n[d]; j++) begin
        n_chk++;
        if (rec[d][j] !== exp_rec(j)) $display("FAIL bp_pix inst%0d #%0d: got %h want %h", d, j, rec[d][j], exp_rec(j));
        else n_pass++;
      end
      n_chk++;
      if (done_cnt[d] !== 1) $display("FAIL bp_done inst%0d: got %0d want 1", d, done_cnt[d]); else n_pass++;
      n_chk++;
      if (credit_bad[d] + addr_bad[d] + idle_en_bad[d] + stall_bad[d] !== 0)
        $display("FAIL bp_protocol inst%0d: got credit=%0d addr=%0d idle_en=%0d stall=%0d want 0",
                 d, credit_bad[d], addr_bad[d], idle_en_bad[d], stall_bad[d]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int i;
    rmode = 2;
    clear_rec();
    cont = 1'b1;
    pulse_start();
    for (i = 0; i < 400 && !(rec_n[0] >= 14 && rec_n[1] >= 14); i++) step();
    cont = 1'b0;
    wait_idle(2, ok);
    rmode = 0;
    n_chk++;
    if (ok !== 1'b1) $display("FAIL b2b_timeout: got busy/done=%0d after 600 cycles, want idle", done_cnt[0]); else n_pass++;
    for (int d = 0; d < NI; d++) begin
      n_chk++;
      if (rec_n[d] !== 2 * NPIX) $display("FAIL b2b_count inst%0d: got %0d want %0d", d, rec_n[d], 2 * NPIX); else n_pass++;
      for (int j = 0; j < 2 * NPIX && j < rec_n[d]; j++) begin
        n_chk++;
        if (rec[d][j] !== exp_rec(j)) $display("FAIL b2b_pix inst%0d #%0d: got %h want %h", d, j, rec[d][j], exp_rec(j));
        else n_pass++;
      end
      n_chk++;
      if (done_cnt[d] !== 2) $display("FAIL b2b_done inst%0d: got %0d want 2", d, done_cnt[d]); else n_pass++;
      n_chk++;
      if (busy_fall[d] !== 1) $display("FAIL b2b_busy_drops inst%0d: got %0d want 1", d, busy_fall[d]); else n_pass++;
      n_chk++;
      if (credit_bad[d] + addr_bad[d] + idle_en_bad[d] + stall_bad[d] !== 0)
        $display("FAIL b2b_protocol inst%0d: got credit=%0d addr=%0d idle_en=%0d stall=%0d want 0",
                 d, credit_bad[d], addr_bad[d], idle_en_bad[d], stall_bad[d]);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    bit ok;
    int snap [NI];
    int i;
    rmode = 0;
    clear_rec();
    pulse_start();
    for (i = 0; i < 200 && rec_n[0] < 5; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int d = 0; d < NI; d++) begin
      n_chk++;
      if ({busy[d], pix_valid[d], mem_en[d]} !== 3'b000)
        $display("FAIL abort_idle inst%0d: got busy=%b valid=%b en=%b want 0 0 0", d, busy[d], pix_valid[d], mem_en[d]);
      else n_pass++;
      snap[d] = rec_n[d];
    end
    for (i = 0; i < 20; i++) step();
    for (int d = 0; d < NI; d++) begin
      n_chk++;
      if (done_cnt[d] !== 0) $display("FAIL abort_no_done inst%0d: got %0d want 0", d, done_cnt[d]); else n_pass++;
      n_chk++;
      if (rec_n[d] !== snap[d]) $display("FAIL abort_quiet inst%0d: got %0d transfers want %0d", d, rec_n[d], snap[d]);
      else n_pass++;
      for (int j = 0; j < rec_n[d] && j < NPIX; j++) begin
        n_chk++;
        if (rec[d][j] !== exp_rec(j)) $display("FAIL abort_prefix inst%0d #%0d: got %h want %h", d, j, rec[d][j], exp_rec(j));
        else n_pass++;
      end
    end
    clear_rec();
    pulse_start();
    wait_idle(1, ok);
    n_chk++;
    if (ok !== 1'b1) $display("FAIL abort_replay_timeout: got busy after 600 cycles, want idle"); else n_pass++;
    for (int d = 0; d < NI; d++) begin
      n_chk++;
      if (rec_n[d] !== NPIX) $display("FAIL replay_count inst%0d: got %0d want %0d", d, rec_n[d], NPIX); else n_pass++;
      for (int j = 0; j < NPIX && j < rec_n[d]; j++) begin
        n_chk++;
        if (rec[d][j] !== exp_rec(j)) $display("FAIL replay_pix inst%0d #%0d: got %h want %h", d, j, rec[d][j], exp_rec(j));
        else n_pass++;
      end
      n_chk++;
      if (done_cnt[d] + addr_bad[d] + credit_bad[d] !== 1)
        $display("FAIL replay_done inst%0d: got done=%0d addr=%0d credit=%0d want 1 0 0",
                 d, done_cnt[d], addr_bad[d], credit_bad[d]);
      else n_pass++;
    end
  endtask

  task automatic test_start_held();
    bit ok;
    rmode = 0;
    clear_rec();
    start = 1'b1;
    for (int i = 0; i < 40; i++) step();
    start = 1'b0;
    wait_idle(1, ok);
    n_chk++;
    if (ok !== 1'b1) $display("FAIL held_timeout: got busy after 600 cycles, want idle"); else n_pass++;
    for (int d = 0; d < NI; d++) begin
      n_chk++;
      if (done_cnt[d] !== 1) $display("FAIL held_frames inst%0d: got %0d want 1", d, done_cnt[d]); else n_pass++;
      n_chk++;
      if (rec_n[d] !== NPIX) $display("FAIL held_count inst%0d: got %0d want %0d", d, rec_n[d], NPIX); else n_pass++;
      for (int j = 0; j < NPIX && j < rec_n[d]; j++) begin
        n_chk++;
        if (rec[d][j] !== exp_rec(j)) $display("FAIL held_pix inst%0d #%0d: got %h want %h", d, j, rec[d][j], exp_rec(j));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    rmode = 0;
    clear_rec();
    pulse_start();
    step(); step(); step();
    rst_n = 1'b0;
    step();
    for (int d = 0; d < NI; d++) begin
      n_chk++;
      if ({mem_en[d], mem_addr[d], pix[d], pix_valid[d], sof[d], eol[d], eof[d], busy[d],
           fdone[d], row[d], col[d]} !== 39'd0)
        $display("FAIL midreset_outputs inst%0d: got en=%b addr=%0d pix=%h v=%b busy=%b row=%0d col=%0d, want all 0",
                 d, mem_en[d], mem_addr[d], pix[d], pix_valid[d], busy[d], row[d], col[d]);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    for (int d = 0; d < NI; d++) begin
      n_chk++;
      if ({done_cnt[d], busy[d]} !== {32'd0, 1'b0})
        $display("FAIL midreset_quiet inst%0d: got done=%0d busy=%b want 0 0", d, done_cnt[d], busy[d]);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    clear_rec();
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_start_held();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
